// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_pkg : segment bit positions and the hex-to-segment decode table     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [7:0] LED_OFF = 8'h00;

  // Active-high g..a patterns, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl_if : SoC-side control bus and board-side display pins     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIGITS = 4,
  parameter int PWM_BITS    = 4,
  parameter int PAGE_W      = (NUM_DIGITS / SCAN_DIGITS > 1) ?
                              $clog2(NUM_DIGITS / SCAN_DIGITS) : 1
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [PAGE_W-1:0]       page;
  logic                    blank_lz;
  logic                    load;
  logic                    en;
  logic [PWM_BITS-1:0]     brightness;
  logic [SCAN_DIGITS-1:0]  LEDSEL;
  logic [7:0]              LEDOUT;
  logic                    frame_done;

  modport master (
    output value, dp, page, blank_lz, load, en, brightness,
    input  LEDSEL, LEDOUT, frame_done
  );

  modport slave (
    input  value, dp, page, blank_lz, load, en, brightness,
    output LEDSEL, LEDOUT, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_lz_blank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_lz_blank : per-slot leading-zero blank mask for the selected page   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_lz_blank #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIGITS = 4,
  parameter int PAGE_W      = 1
) (
  input  wire logic [4*NUM_DIGITS-1:0] value,
  input  wire logic [PAGE_W-1:0]       page,
  input  wire logic                    blank_lz,
  output      logic [SCAN_DIGITS-1:0]  mask
);
  localparam int K_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // w_zero_from[k]: every nibble at index k and above is zero.
  logic [NUM_DIGITS-1:0] w_zero_from;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
      assign w_zero_from[k] = ~|value[4*NUM_DIGITS-1:4*k];
    end

    for (genvar i = 0; i < SCAN_DIGITS; i++) begin : g_slot
      logic [K_W-1:0] w_k;
      assign w_k     = K_W'(page) * K_W'(SCAN_DIGITS) + K_W'(i);
      assign mask[i] = blank_lz && w_zero_from[w_k] && (w_k != '0);
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed N-digit hex display scanner with paging,    |
// |                  frame-aligned updates, blanking and PWM brightness      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIGITS = 4,
  parameter int CLK_DIV     = 20000,
  parameter int PWM_BITS    = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input wire logic        clk,
  input wire logic        rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int PAGE_W = (NUM_DIGITS / SCAN_DIGITS > 1) ?
                          $clog2(NUM_DIGITS / SCAN_DIGITS) : 1;
  localparam int PRE_W  = $clog2(CLK_DIV);
  localparam int IDX_W  = (SCAN_DIGITS > 1) ? $clog2(SCAN_DIGITS) : 1;
  localparam int K_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic                   POL     = (ACTIVE_LOW != 0);
  localparam logic [SCAN_DIGITS-1:0] SEL_OFF = {SCAN_DIGITS{POL}};
  localparam logic [7:0]             OUT_OFF = LED_OFF ^ {8{POL}};

  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [PWM_BITS-1:0]     r_pwm;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_pend_value, r_act_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [PAGE_W-1:0]       r_pend_page, r_act_page;
  logic                    r_pend_blz, r_act_blz;
  logic [SCAN_DIGITS-1:0]  r_led_sel;
  logic [7:0]              r_led_out;
  logic                    r_frame_done;

  logic                   w_tick, w_wrap, w_lit, w_blank;
  logic [K_W-1:0]         w_k;
  logic [3:0]             w_nib;
  logic [6:0]             w_seg;
  logic [7:0]             w_led_hi;
  logic [SCAN_DIGITS-1:0] w_sel_hi, w_blank_mask;

  assign w_tick = (r_pre == PRE_W'(CLK_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IDX_W'(SCAN_DIGITS - 1));

  seg7_lz_blank #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIGITS(SCAN_DIGITS),
    .PAGE_W     (PAGE_W)
  ) u_lz_blank (
    .value   (r_act_value),
    .page    (r_act_page),
    .blank_lz(r_act_blz),
    .mask    (w_blank_mask)
  );

  assign w_k     = K_W'(r_act_page) * K_W'(SCAN_DIGITS) + K_W'(r_idx);
  assign w_nib   = r_act_value[{w_k, 2'b00} +: 4];
  assign w_blank = w_blank_mask[r_idx];
  assign w_seg   = w_blank ? SEG_OFF : hex_to_seg(w_nib);

  always_comb begin
    w_led_hi              = LED_OFF;
    w_led_hi[SEG_G:SEG_A] = w_seg;
    w_led_hi[SEG_DP]      = r_act_dp[w_k];
  end

  // The first cycle of every slot is dead time so the previous digit's
  // segments never bleed into the newly selected digit.
  assign w_lit    = bus.en && (r_pwm <= bus.brightness) && (r_pre != '0);
  assign w_sel_hi = w_lit ? (SCAN_DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_pwm <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      r_pwm <= r_pwm + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_W'(SCAN_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Active set only changes at a frame wrap; a load on the wrap itself wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend       <= 1'b0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_page  <= '0;
      r_pend_blz   <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_page   <= '0;
      r_act_blz    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend       <= 1'b1;
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp;
        r_pend_page  <= bus.page;
        r_pend_blz   <= bus.blank_lz;
      end
      if (w_wrap && (r_pend || bus.load)) begin
        r_pend      <= 1'b0;
        r_act_value <= bus.load ? bus.value    : r_pend_value;
        r_act_dp    <= bus.load ? bus.dp       : r_pend_dp;
        r_act_page  <= bus.load ? bus.page     : r_pend_page;
        r_act_blz   <= bus.load ? bus.blank_lz : r_pend_blz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led_sel    <= SEL_OFF;
      r_led_out    <= OUT_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_led_sel    <= w_sel_hi ^ SEL_OFF;
      r_led_out    <= w_led_hi ^ OUT_OFF;
      r_frame_done <= w_wrap;
    end
  end

  assign bus.LEDSEL     = r_led_sel;
  assign bus.LEDOUT     = r_led_out;
  assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
